// File: rtl/multi_cycle_pkg.sv
// Shared types and decode helpers for the multi-cycle RV32I core.
package multi_cycle_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

    // Only the instruction bits above the opcode carry immediate fields.
    function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:7] ir);
        case (fmt)
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

    function automatic alu_op_e alu_op_of(input logic r_type, input logic [2:0] funct3,
                                          input logic [6:0] funct7);
        case (funct3)
            3'b000:  return (r_type && (funct7 == 7'b0100000)) ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b010:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_reg_file.sv
// Architectural register file: two async read ports, one sync write port, x0 reads zero.
module mc_reg_file #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    localparam int AW = $clog2(NREGS);

    logic [31:0]   regs_q [NREGS];
    logic [AW-1:0] ra1_s;
    logic [AW-1:0] ra2_s;
    logic [AW-1:0] wa_s;

    assign ra1_s = raddr1[AW-1:0];
    assign ra2_s = raddr2[AW-1:0];
    assign wa_s  = waddr[AW-1:0];

    // Read ports with x0 forced to zero.
    always_comb begin
        rdata1 = (ra1_s == {AW{1'b0}}) ? 32'd0 : regs_q[ra1_s];
        rdata2 = (ra2_s == {AW{1'b0}}) ? 32'd0 : regs_q[ra2_s];
    end

    // Write port; async reset clears every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we && (wa_s != {AW{1'b0}})) begin
            regs_q[wa_s] <= wdata;
        end
    end

endmodule

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I subset core with a single req/ready memory port.
// Define MULTI_CYCLE_CORE_TRAP_EN to trap on illegal opcodes and misaligned addresses.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] pc_o,
    output logic        halted
);
    import multi_cycle_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;

    logic [6:0]  opcode_s;
    logic [31:0] imm_s, rs1_data_s, rs2_data_s;
    logic [31:0] alu_a_s, alu_b_s, alu_res_s;
    alu_op_e     alu_op_s;
    logic        req_s, we_s, retire_s, rf_we_s;
    logic [31:0] addr_s, rf_wdata_s;

    assign opcode_s = ir_q[6:0];
    assign imm_s    = imm_gen(imm_fmt_of(opcode_s), ir_q[31:7]);

    mc_reg_file #(.NREGS(NREGS)) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (ir_q[19:15]),
        .raddr2 (ir_q[24:20]),
        .rdata1 (rs1_data_s),
        .rdata2 (rs2_data_s),
        .we     (rf_we_s),
        .waddr  (ir_q[11:7]),
        .wdata  (rf_wdata_s)
    );

    // Shared ALU.
    always_comb begin
        case (alu_op_s)
            ALU_SUB: alu_res_s = alu_a_s - alu_b_s;
            ALU_AND: alu_res_s = alu_a_s & alu_b_s;
            ALU_OR:  alu_res_s = alu_a_s | alu_b_s;
            ALU_SLT: alu_res_s = {31'd0, $signed(alu_a_s) < $signed(alu_b_s)};
            default: alu_res_s = alu_a_s + alu_b_s;
        endcase
    end

    // Next-state, datapath register updates and memory/retire outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        old_pc_d   = old_pc_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        req_s      = 1'b0;
        we_s       = 1'b0;
        addr_s     = pc_q;
        retire_s   = 1'b0;
        rf_we_s    = 1'b0;
        rf_wdata_s = alu_out_q;
        alu_a_s    = a_q;
        alu_b_s    = imm_s;
        alu_op_s   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                req_s = 1'b1;
                if (mem_ready) begin
                    ir_d     = mem_rdata;
                    old_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_DECODE;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d       = rs1_data_s;
                b_d       = rs2_data_s;
                alu_a_s   = old_pc_q;
                alu_out_d = alu_res_s;
                case (opcode_s)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
`ifdef MULTI_CYCLE_CORE_TRAP_EN
                        state_d  = S_TRAP;
`else
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
`ifdef MULTI_CYCLE_CORE_TRAP_EN
                if (alu_res_s[1:0] != 2'b00) begin
                    state_d = S_TRAP;
                end else begin
                    alu_out_d = alu_res_s;
                    state_d   = (opcode_s == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
`else
                alu_out_d = {alu_res_s[31:2], 2'b00};
                state_d   = (opcode_s == OP_SW) ? S_MEMWRITE : S_MEMREAD;
`endif
            end
            S_MEMREAD: begin
                req_s  = 1'b1;
                addr_s = alu_out_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                rf_we_s    = 1'b1;
                rf_wdata_s = mdr_q;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                req_s  = 1'b1;
                we_s   = 1'b1;
                addr_s = alu_out_q;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEMWRITE;
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                if (state_q == S_EXEC_R) begin
                    alu_b_s  = b_q;
                    alu_op_s = alu_op_of(1'b1, ir_q[14:12], ir_q[31:25]);
                end else begin
                    alu_op_s = alu_op_of(1'b0, ir_q[14:12], ir_q[31:25]);
                end
                alu_out_d = alu_res_s;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we_s  = 1'b1;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
                if (a_q == b_q) begin
`ifdef MULTI_CYCLE_CORE_TRAP_EN
                    if (alu_out_q[1]) begin
                        retire_s = 1'b0;
                        state_d  = S_TRAP;
                    end else begin
                        pc_d = alu_out_q;
                    end
`else
                    pc_d = {alu_out_q[31:2], 2'b00};
`endif
                end else begin
                    pc_d = pc_q;
                end
            end
            S_JAL: begin
                state_d    = S_FETCH;
                retire_s   = 1'b1;
                rf_we_s    = 1'b1;
                rf_wdata_s = old_pc_q + 32'd4;
`ifdef MULTI_CYCLE_CORE_TRAP_EN
                if (alu_out_q[1]) begin
                    retire_s = 1'b0;
                    rf_we_s  = 1'b0;
                    state_d  = S_TRAP;
                end else begin
                    pc_d = alu_out_q;
                end
`else
                pc_d = {alu_out_q[31:2], 2'b00};
`endif
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            old_pc_q  <= 32'd0;
            ir_q      <= 32'd0;
            mdr_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    // Reset drops any request at once, even mid-transfer.
    assign mem_req   = req_s & ~rst;
    assign mem_we    = we_s;
    assign mem_addr  = addr_s;
    assign mem_wdata = b_q;
    assign retire    = retire_s & ~rst;
    assign pc_o      = pc_q;
`ifdef MULTI_CYCLE_CORE_TRAP_EN
    assign halted    = (state_q == S_TRAP);
`else
    assign halted    = 1'b0;
`endif

endmodule
